// File: rtl/rs_issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue_if
//  Description : Issue lanes between the reservation station and the
//                functional units. One lane per FU; each lane carries a
//                valid/ready handshake plus the operand and instruction
//                payload. The master modport is the RS (issuing) side, the
//                slave modport is the FU (consuming) side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rs_issue_queue_if #(
  parameter int NUM_OF_FU = 2,
  parameter int PREG_W    = 6,
  parameter int VAL_W     = 32,
  parameter int ADDR_W    = 32,
  parameter int ROB_W     = 4,
  parameter int CTRL_W    = 8
);

  logic [NUM_OF_FU-1:0]             valid;
  logic [NUM_OF_FU-1:0]             ready;
  logic [NUM_OF_FU-1:0][VAL_W-1:0]  src1_reg_val;
  logic [NUM_OF_FU-1:0][VAL_W-1:0]  src2_reg_val;
  logic [NUM_OF_FU-1:0][PREG_W-1:0] dst;
  logic [NUM_OF_FU-1:0][CTRL_W-1:0] control;
  logic [NUM_OF_FU-1:0][VAL_W-1:0]  imm;
  logic [NUM_OF_FU-1:0][ADDR_W-1:0] pc;
  logic [NUM_OF_FU-1:0][ROB_W-1:0]  new_inst_tag;

  // Reservation-station side: drives the payload, samples ready
  modport master (
    output valid, src1_reg_val, src2_reg_val, dst, control, imm, pc, new_inst_tag,
    input  ready
  );

  // Functional-unit side: consumes the payload, drives ready
  modport slave (
    input  valid, src1_reg_val, src2_reg_val, dst, control, imm, pc, new_inst_tag,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue
//  Description : Reservation-station issue queue. Holds renamed instructions
//                until both sources are available (snooping the CDB for
//                wakeup), then issues the oldest ready entries to up to
//                NUM_OF_FU functional units through registered issue lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_queue #(
  parameter int NUM_OF_FU = 2,
  parameter int RS_DEPTH  = 8,
  parameter int CDB_PORTS = 2,
  parameter int PREG_W    = 6,
  parameter int VAL_W     = 32,
  parameter int ADDR_W    = 32,
  parameter int ROB_W     = 4,
  parameter int CTRL_W    = 8
) (
  input  wire logic                                 clk,
  input  wire logic                                 rst_n,
  input  wire logic                                 flush,
  input  wire logic                                 alloc_valid,
  output logic                                      alloc_ready,
  input  wire logic [PREG_W-1:0]                    alloc_src1_tag,
  input  wire logic                                 alloc_src1_rdy,
  input  wire logic [VAL_W-1:0]                     alloc_src1_val,
  input  wire logic [PREG_W-1:0]                    alloc_src2_tag,
  input  wire logic                                 alloc_src2_rdy,
  input  wire logic [VAL_W-1:0]                     alloc_src2_val,
  input  wire logic [PREG_W-1:0]                    alloc_dst,
  input  wire logic [CTRL_W-1:0]                    alloc_control,
  input  wire logic [VAL_W-1:0]                     alloc_imm,
  input  wire logic [ADDR_W-1:0]                    alloc_pc,
  input  wire logic [ROB_W-1:0]                     alloc_rob_tag,
  input  wire logic [CDB_PORTS-1:0]                 cdb_valid,
  input  wire logic [CDB_PORTS-1:0][PREG_W-1:0]     cdb_tag,
  input  wire logic [CDB_PORTS-1:0][VAL_W-1:0]      cdb_val,
  rs_issue_queue_if.master                          fu_if,
  output logic [$clog2(RS_DEPTH):0]                 rs_count
);

  localparam int C_IDX_W = $clog2(RS_DEPTH);
  localparam int C_CNT_W = C_IDX_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(RS_DEPTH);

  // Entry storage
  logic [RS_DEPTH-1:0]               valid_q, valid_d;
  logic [RS_DEPTH-1:0]               s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [RS_DEPTH-1:0][PREG_W-1:0]   s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [RS_DEPTH-1:0][VAL_W-1:0]    s1_val_q, s1_val_d, s2_val_q, s2_val_d;
  logic [RS_DEPTH-1:0][PREG_W-1:0]   dst_q, dst_d;
  logic [RS_DEPTH-1:0][CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [RS_DEPTH-1:0][VAL_W-1:0]    imm_q, imm_d;
  logic [RS_DEPTH-1:0][ADDR_W-1:0]   pc_q, pc_d;
  logic [RS_DEPTH-1:0][ROB_W-1:0]    rob_q, rob_d;
  // older_q[i][j] = 1 when entry i was allocated before entry j
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
  logic [C_CNT_W-1:0]                count_q, count_d;

  // Issue lane output registers
  logic [NUM_OF_FU-1:0]              lane_valid_q, lane_valid_d;
  logic [NUM_OF_FU-1:0][VAL_W-1:0]   lane_s1_q, lane_s1_d, lane_s2_q, lane_s2_d;
  logic [NUM_OF_FU-1:0][PREG_W-1:0]  lane_dst_q, lane_dst_d;
  logic [NUM_OF_FU-1:0][CTRL_W-1:0]  lane_ctrl_q, lane_ctrl_d;
  logic [NUM_OF_FU-1:0][VAL_W-1:0]   lane_imm_q, lane_imm_d;
  logic [NUM_OF_FU-1:0][ADDR_W-1:0]  lane_pc_q, lane_pc_d;
  logic [NUM_OF_FU-1:0][ROB_W-1:0]   lane_rob_q, lane_rob_d;

  // Combinational helpers
  logic [RS_DEPTH-1:0]               w_eligible;
  logic [NUM_OF_FU-1:0]              w_lane_free;
  logic [NUM_OF_FU-1:0]              w_sel_v;
  logic [NUM_OF_FU-1:0][C_IDX_W-1:0] w_sel_idx;
  logic [RS_DEPTH-1:0]               w_taken;
  logic [RS_DEPTH-1:0]               w_cand;
  logic                              w_is_old;
  logic [C_IDX_W-1:0]                w_alloc_idx;
  logic                              w_alloc_fire;
  logic [C_CNT_W-1:0]                w_issued;

  // Readiness is judged on registered state only, so a wakeup at edge t
  // makes the entry selectable from cycle t+1.
  assign w_eligible   = valid_q & s1_rdy_q & s2_rdy_q;
  assign w_lane_free  = ~lane_valid_q | fu_if.ready;
  assign alloc_ready  = (count_q < C_DEPTH);
  assign w_alloc_fire = alloc_valid & alloc_ready;
  assign rs_count     = count_q;

  assign fu_if.valid        = lane_valid_q;
  assign fu_if.src1_reg_val = lane_s1_q;
  assign fu_if.src2_reg_val = lane_s2_q;
  assign fu_if.dst          = lane_dst_q;
  assign fu_if.control      = lane_ctrl_q;
  assign fu_if.imm          = lane_imm_q;
  assign fu_if.pc           = lane_pc_q;
  assign fu_if.new_inst_tag = lane_rob_q;

  // Per free lane, in lane order, pick the oldest eligible entry not already taken
  always_comb begin
    w_sel_v   = '0;
    w_sel_idx = '0;
    w_taken   = '0;
    w_cand    = '0;
    w_is_old  = 1'b0;
    for (int k = 0; k < NUM_OF_FU; k++) begin
      w_cand = w_eligible & ~w_taken;
      if (w_lane_free[k]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          w_is_old = w_cand[i];
          for (int j = 0; j < RS_DEPTH; j++) begin
            if (j != i && w_cand[j] && !older_q[i][j]) begin
              w_is_old = 1'b0;
            end
          end
          if (w_is_old) begin
            w_sel_v[k]   = 1'b1;
            w_sel_idx[k] = C_IDX_W'(i);
          end
        end
        if (w_sel_v[k]) begin
          w_taken[w_sel_idx[k]] = 1'b1;
        end
      end
    end
  end

  // Lowest-index free entry from registered occupancy (issue this cycle frees nothing yet)
  always_comb begin
    w_alloc_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        w_alloc_idx = C_IDX_W'(i);
      end
    end
  end

  // Next state: issue into lanes, CDB wakeup, allocation with bypass, occupancy
  always_comb begin
    valid_d      = valid_q;
    s1_rdy_d     = s1_rdy_q;
    s2_rdy_d     = s2_rdy_q;
    s1_tag_d     = s1_tag_q;
    s2_tag_d     = s2_tag_q;
    s1_val_d     = s1_val_q;
    s2_val_d     = s2_val_q;
    dst_d        = dst_q;
    ctrl_d       = ctrl_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    rob_d        = rob_q;
    older_d      = older_q;
    lane_valid_d = lane_valid_q;
    lane_s1_d    = lane_s1_q;
    lane_s2_d    = lane_s2_q;
    lane_dst_d   = lane_dst_q;
    lane_ctrl_d  = lane_ctrl_q;
    lane_imm_d   = lane_imm_q;
    lane_pc_d    = lane_pc_q;
    lane_rob_d   = lane_rob_q;
    w_issued     = '0;

    // A busy lane (valid & !ready) keeps its payload untouched
    for (int k = 0; k < NUM_OF_FU; k++) begin
      if (w_lane_free[k]) begin
        lane_valid_d[k] = w_sel_v[k];
        if (w_sel_v[k]) begin
          lane_s1_d[k]            = s1_val_q[w_sel_idx[k]];
          lane_s2_d[k]            = s2_val_q[w_sel_idx[k]];
          lane_dst_d[k]           = dst_q[w_sel_idx[k]];
          lane_ctrl_d[k]          = ctrl_q[w_sel_idx[k]];
          lane_imm_d[k]           = imm_q[w_sel_idx[k]];
          lane_pc_d[k]            = pc_q[w_sel_idx[k]];
          lane_rob_d[k]           = rob_q[w_sel_idx[k]];
          valid_d[w_sel_idx[k]]   = 1'b0;
          w_issued                = w_issued + C_CNT_W'(1);
        end
      end
    end

    // Ports scanned high to low so the lowest matching port wins
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (valid_q[i] && cdb_valid[p]) begin
          if (!s1_rdy_q[i] && (cdb_tag[p] == s1_tag_q[i])) begin
            s1_rdy_d[i] = 1'b1;
            s1_val_d[i] = cdb_val[p];
          end
          if (!s2_rdy_q[i] && (cdb_tag[p] == s2_tag_q[i])) begin
            s2_rdy_d[i] = 1'b1;
            s2_val_d[i] = cdb_val[p];
          end
        end
      end
    end

    if (w_alloc_fire) begin
      valid_d[w_alloc_idx]  = 1'b1;
      s1_tag_d[w_alloc_idx] = alloc_src1_tag;
      s1_rdy_d[w_alloc_idx] = alloc_src1_rdy;
      s1_val_d[w_alloc_idx] = alloc_src1_val;
      s2_tag_d[w_alloc_idx] = alloc_src2_tag;
      s2_rdy_d[w_alloc_idx] = alloc_src2_rdy;
      s2_val_d[w_alloc_idx] = alloc_src2_val;
      dst_d[w_alloc_idx]    = alloc_dst;
      ctrl_d[w_alloc_idx]   = alloc_control;
      imm_d[w_alloc_idx]    = alloc_imm;
      pc_d[w_alloc_idx]     = alloc_pc;
      rob_d[w_alloc_idx]    = alloc_rob_tag;
      // Same-cycle broadcast of a pending source tag is captured on entry
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p]) begin
          if (!alloc_src1_rdy && (cdb_tag[p] == alloc_src1_tag)) begin
            s1_rdy_d[w_alloc_idx] = 1'b1;
            s1_val_d[w_alloc_idx] = cdb_val[p];
          end
          if (!alloc_src2_rdy && (cdb_tag[p] == alloc_src2_tag)) begin
            s2_rdy_d[w_alloc_idx] = 1'b1;
            s2_val_d[w_alloc_idx] = cdb_val[p];
          end
        end
      end
      // The new entry is younger than every other entry
      for (int j = 0; j < RS_DEPTH; j++) begin
        older_d[w_alloc_idx][j] = 1'b0;
        older_d[j][w_alloc_idx] = (C_IDX_W'(j) != w_alloc_idx);
      end
    end

    count_d = count_q + C_CNT_W'(w_alloc_fire) - w_issued;
  end

  // State registers; reset and flush both clear everything and override same-cycle activity
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid_q      <= '0;
      s1_rdy_q     <= '0;
      s2_rdy_q     <= '0;
      s1_tag_q     <= '0;
      s2_tag_q     <= '0;
      s1_val_q     <= '0;
      s2_val_q     <= '0;
      dst_q        <= '0;
      ctrl_q       <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      rob_q        <= '0;
      older_q      <= '0;
      count_q      <= '0;
      lane_valid_q <= '0;
      lane_s1_q    <= '0;
      lane_s2_q    <= '0;
      lane_dst_q   <= '0;
      lane_ctrl_q  <= '0;
      lane_imm_q   <= '0;
      lane_pc_q    <= '0;
      lane_rob_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      s1_rdy_q     <= s1_rdy_d;
      s2_rdy_q     <= s2_rdy_d;
      s1_tag_q     <= s1_tag_d;
      s2_tag_q     <= s2_tag_d;
      s1_val_q     <= s1_val_d;
      s2_val_q     <= s2_val_d;
      dst_q        <= dst_d;
      ctrl_q       <= ctrl_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      rob_q        <= rob_d;
      older_q      <= older_d;
      count_q      <= count_d;
      lane_valid_q <= lane_valid_d;
      lane_s1_q    <= lane_s1_d;
      lane_s2_q    <= lane_s2_d;
      lane_dst_q   <= lane_dst_d;
      lane_ctrl_q  <= lane_ctrl_d;
      lane_imm_q   <= lane_imm_d;
      lane_pc_q    <= lane_pc_d;
      lane_rob_q   <= lane_rob_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_issue_queue
//  Description : Self-checking bench for rs_issue_queue. Directed scenarios
//                followed by random traffic, all compared every cycle with
//                an in-order queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_queue;

  localparam int NF = 2;
  localparam int D  = 8;
  localparam int P  = 2;
  localparam int PW = 6;
  localparam int VW = 32;
  localparam int AW = 32;
  localparam int RW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic alloc_valid, alloc_ready;
  logic [PW-1:0] alloc_src1_tag, alloc_src2_tag, alloc_dst;
  logic alloc_src1_rdy, alloc_src2_rdy;
  logic [VW-1:0] alloc_src1_val, alloc_src2_val, alloc_imm;
  logic [CW-1:0] alloc_control;
  logic [AW-1:0] alloc_pc;
  logic [RW-1:0] alloc_rob_tag;
  logic [P-1:0] cdb_valid;
  logic [P-1:0][PW-1:0] cdb_tag;
  logic [P-1:0][VW-1:0] cdb_val;
  logic [$clog2(D):0] rs_count;

  always #5 clk = ~clk;

  rs_issue_queue_if #(.NUM_OF_FU(NF), .PREG_W(PW), .VAL_W(VW), .ADDR_W(AW),
                      .ROB_W(RW), .CTRL_W(CW)) fu_if ();

  rs_issue_queue #(.NUM_OF_FU(NF), .RS_DEPTH(D), .CDB_PORTS(P), .PREG_W(PW),
                   .VAL_W(VW), .ADDR_W(AW), .ROB_W(RW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src1_rdy(alloc_src1_rdy), .alloc_src1_val(alloc_src1_val),
    .alloc_src2_tag(alloc_src2_tag), .alloc_src2_rdy(alloc_src2_rdy), .alloc_src2_val(alloc_src2_val),
    .alloc_dst(alloc_dst), .alloc_control(alloc_control), .alloc_imm(alloc_imm),
    .alloc_pc(alloc_pc), .alloc_rob_tag(alloc_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .fu_if(fu_if.master), .rs_count(rs_count)
  );

  // Reference model: waiting instructions in allocation order, plus lane contents
  typedef struct packed {
    logic [PW-1:0] t1, t2;
    logic          r1, r2;
    logic [VW-1:0] v1, v2, imm;
    logic [AW-1:0] pc;
    logic [PW-1:0] dst;
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rob;
  } ent_t;

  ent_t      mq[$];
  ent_t      ml[NF];
  bit [NF-1:0] mv;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    ent_t nq[$];
    int   picked[$];
    int   sz0;
    bit   tk;
    ent_t e;
    if (!rst_n || flush) begin
      mq.delete();
      mv = '0;
      return;
    end
    sz0 = mq.size();
    for (int k = 0; k < NF; k++) begin
      if (!mv[k] || fu_if.ready[k]) begin
        mv[k] = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          tk = 1'b0;
          foreach (picked[m]) if (picked[m] == i) tk = 1'b1;
          if (!tk && mq[i].r1 && mq[i].r2) begin
            ml[k] = mq[i];
            mv[k] = 1'b1;
            picked.push_back(i);
            break;
          end
        end
      end
    end
    for (int i = 0; i < mq.size(); i++) begin
      tk = 1'b0;
      foreach (picked[m]) if (picked[m] == i) tk = 1'b1;
      if (!tk) nq.push_back(mq[i]);
    end
    if (alloc_valid && sz0 < D) begin
      e.t1 = alloc_src1_tag; e.r1 = alloc_src1_rdy; e.v1 = alloc_src1_val;
      e.t2 = alloc_src2_tag; e.r2 = alloc_src2_rdy; e.v2 = alloc_src2_val;
      e.imm = alloc_imm; e.pc = alloc_pc; e.dst = alloc_dst;
      e.ctrl = alloc_control; e.rob = alloc_rob_tag;
      nq.push_back(e);
    end
    // Broadcast wakes waiting sources, including a source arriving this cycle
    foreach (nq[i]) begin
      for (int p = 0; p < P; p++) begin
        if (cdb_valid[p]) begin
          if (!nq[i].r1 && cdb_tag[p] == nq[i].t1) begin nq[i].r1 = 1'b1; nq[i].v1 = cdb_val[p]; end
          if (!nq[i].r2 && cdb_tag[p] == nq[i].t2) begin nq[i].r2 = 1'b1; nq[i].v2 = cdb_val[p]; end
        end
      end
    end
    mq = nq;
  endtask

  task automatic compare();
    check("rs_count", rs_count, mq.size());
    check("alloc_ready", alloc_ready, mq.size() < D);
    for (int k = 0; k < NF; k++) begin
      check($sformatf("lane%0d_valid", k), fu_if.valid[k], mv[k]);
      if (mv[k]) begin
        check($sformatf("lane%0d_src1", k), fu_if.src1_reg_val[k], ml[k].v1);
        check($sformatf("lane%0d_src2", k), fu_if.src2_reg_val[k], ml[k].v2);
        check($sformatf("lane%0d_rob", k), fu_if.new_inst_tag[k], ml[k].rob);
        check($sformatf("lane%0d_dst", k), fu_if.dst[k], ml[k].dst);
        check($sformatf("lane%0d_imm_pc_ctrl", k),
              {fu_if.imm[k], fu_if.pc[k], fu_if.control[k]}, {ml[k].imm, ml[k].pc, ml[k].ctrl});
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = '0;
    flush       = 1'b0;
  endtask

  task automatic do_alloc(input logic [PW-1:0] t1, input bit r1,
                          input logic [PW-1:0] t2, input bit r2, input logic [RW-1:0] rob);
    alloc_valid    = 1'b1;
    alloc_src1_tag = t1; alloc_src1_rdy = r1; alloc_src1_val = $urandom;
    alloc_src2_tag = t2; alloc_src2_rdy = r2; alloc_src2_val = $urandom;
    alloc_dst      = PW'($urandom);
    alloc_control  = CW'($urandom);
    alloc_imm      = $urandom;
    alloc_pc       = $urandom;
    alloc_rob_tag  = rob;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    do_alloc(0, 1, 0, 1, 0);
    alloc_valid = 1'b0;
    cdb_tag = '0; cdb_val = '0;
    fu_if.ready = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_count", rs_count, 0);
    check("reset_alloc_ready", alloc_ready, 1);
    check("reset_valid", fu_if.valid, 0);

    // Ready-at-alloc instruction reaches lane 0 two edges later
    fu_if.ready = 2'b11;
    do_alloc(1, 1, 2, 1, 3); tick();
    idle(); tick();
    check("lat_valid0", fu_if.valid[0], 1);
    check("lat_rob", fu_if.new_inst_tag[0], 3);
    check("lat_count", rs_count, 0);
    tick();

    // Wakeup from CDB, issue the cycle after
    do_alloc(17, 0, 5, 1, 4); tick();
    idle(); tick();
    cdb_valid = 2'b01; cdb_tag[0] = 17; cdb_val[0] = 32'hDEAD; tick();
    idle(); tick();
    check("wake_valid", fu_if.valid[0], 1);
    check("wake_src1", fu_if.src1_reg_val[0], 32'hDEAD);
    tick();

    // Fill the queue with lanes stalled; full blocks alloc; one transfer reopens it
    fu_if.ready = 2'b00;
    for (int i = 0; i < 10; i++) begin
      do_alloc(0, 1, 0, 1, RW'(i)); tick();
    end
    check("full_alloc_ready", alloc_ready, 0);
    check("full_count", rs_count, 8);
    do_alloc(0, 1, 0, 1, 15); tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    fu_if.ready = 2'b01; tick();
    check("reopen_alloc_ready", alloc_ready, 1);
    check("reopen_rob", fu_if.new_inst_tag[0], 2);
    fu_if.ready = 2'b11;
    for (int i = 0; i < 10; i++) tick();

    // Three simultaneously woken entries issue oldest first across lanes
    fu_if.ready = 2'b00;
    do_alloc(20, 0, 1, 1, 10); tick();
    do_alloc(20, 0, 1, 1, 11); tick();
    do_alloc(20, 0, 1, 1, 12); tick();
    idle(); cdb_valid = 2'b10; cdb_tag[1] = 20; cdb_val[1] = 32'h1234; tick();
    idle(); tick();
    check("age_lane0", fu_if.new_inst_tag[0], 10);
    check("age_lane1", fu_if.new_inst_tag[1], 11);
    fu_if.ready = 2'b11; tick();
    check("age_lane0_next", fu_if.new_inst_tag[0], 12);
    check("age_lane1_drop", fu_if.valid[1], 0);
    tick();

    // Flush with entries and busy lanes; alloc in the flush cycle is dropped
    fu_if.ready = 2'b00;
    for (int i = 0; i < 7; i++) begin
      do_alloc(0, 1, 0, 1, RW'(i)); tick();
    end
    check("preflush_count", rs_count, 5);
    do_alloc(0, 1, 0, 1, 9); flush = 1'b1; tick();
    check("flush_count", rs_count, 0);
    check("flush_valid", fu_if.valid, 0);
    check("flush_alloc_ready", alloc_ready, 1);
    idle(); tick();
    check("flush_alloc_dropped", rs_count, 0);

    for (int i = 0; i < 3; i++) begin
      do_alloc(0, 1, 0, 1, RW'(i)); tick();
    end
    rst_n = 1'b0; do_alloc(0, 1, 0, 1, 7); tick();
    rst_n = 1'b1; idle(); tick();
    check("rst_count", rs_count, 0);
    check("rst_valid", fu_if.valid, 0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 6)
        do_alloc(PW'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                 PW'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), RW'($urandom));
      else
        alloc_valid = 1'b0;
      for (int p = 0; p < P; p++) begin
        cdb_valid[p] = 1'($urandom_range(0, 1));
        cdb_tag[p]   = PW'($urandom_range(0, 15));
        cdb_val[p]   = $urandom;
      end
      if (cdb_tag[1] == cdb_tag[0]) cdb_valid[1] = 1'b0;
      fu_if.ready = NF'($urandom);
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end

    idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
